// File: rtl/mem_loader.sv
// mem_loader: streams instruction and data words into two external memories,
// enables the CPU for a fixed number of cycles, then streams data words back out.
module mem_loader #(
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_len,
    input  logic [CNT_W-1:0] dmem_len,
    input  logic [CNT_W-1:0] dump_len,
    input  logic [31:0]      run_cycles,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             cpu_enable,
    output logic [31:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [31:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [31:0]      wdata_ext_2,
    input  logic [31:0]      rdata_ext_2,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, FIN
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] ilen_reg, ilen_next;
    logic [CNT_W-1:0] dlen_reg, dlen_next;
    logic [CNT_W-1:0] ulen_reg, ulen_next;
    logic [31:0]      rcyc_reg, rcyc_next;
    logic [31:0]      run_reg, run_next;
    logic [31:0]      rdata_reg, rdata_next;

    logic        load_i_xfer;
    logic        load_d_xfer;
    logic [31:0] addr_val;

    // First phase at or after stage 'from' (0=LOAD_I,1=LOAD_D,2=RUN,3=DUMP)
    // whose length is non-zero; zero-length phases are skipped.
    function automatic state_t first_phase(
        input logic [1:0]       from,
        input logic [CNT_W-1:0] il,
        input logic [CNT_W-1:0] dl,
        input logic [CNT_W-1:0] ul,
        input logic [31:0]      rc
    );
        if (from == 2'd0 && il != '0) return LOAD_I;
        if (from <= 2'd1 && dl != '0) return LOAD_D;
        if (from <= 2'd2 && rc != '0) return RUN;
        if (ul != '0) return DUMP_RD;
        return FIN;
    endfunction

    assign addr_val    = 32'(cnt_reg) * 32'(ADDR_STEP);
    assign load_i_xfer = (state_reg == LOAD_I) && in_valid;
    assign load_d_xfer = (state_reg == LOAD_D) && in_valid;

    assign in_ready    = (state_reg == LOAD_I) || (state_reg == LOAD_D);
    assign wen_ext     = load_i_xfer;
    assign ren_ext     = 1'b0;
    assign addr_ext    = load_i_xfer ? addr_val : 32'd0;
    assign wdata_ext   = load_i_xfer ? in_data : 32'd0;

    assign wen_ext_2   = load_d_xfer;
    assign ren_ext_2   = (state_reg == DUMP_RD);
    assign addr_ext_2  = (load_d_xfer || state_reg == DUMP_RD) ? addr_val : 32'd0;
    assign wdata_ext_2 = load_d_xfer ? in_data : 32'd0;

    assign cpu_enable  = (state_reg == RUN);
    assign out_valid   = (state_reg == DUMP_OUT);
    assign out_data    = rdata_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == FIN);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ilen_next  = ilen_reg;
        dlen_next  = dlen_reg;
        ulen_next  = ulen_reg;
        rcyc_next  = rcyc_reg;
        run_next   = run_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    ilen_next  = imem_len;
                    dlen_next  = dmem_len;
                    ulen_next  = dump_len;
                    rcyc_next  = run_cycles;
                    cnt_next   = '0;
                    run_next   = 32'd0;
                    state_next = first_phase(2'd0, imem_len, dmem_len, dump_len, run_cycles);
                end
            end
            LOAD_I: begin
                if (load_i_xfer) begin
                    if (cnt_reg == ilen_reg - 1'b1) begin
                        cnt_next   = '0;
                        state_next = first_phase(2'd1, ilen_reg, dlen_reg, ulen_reg, rcyc_reg);
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            LOAD_D: begin
                if (load_d_xfer) begin
                    if (cnt_reg == dlen_reg - 1'b1) begin
                        cnt_next   = '0;
                        state_next = first_phase(2'd2, ilen_reg, dlen_reg, ulen_reg, rcyc_reg);
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RUN: begin
                if (run_reg == rcyc_reg - 32'd1) begin
                    run_next   = 32'd0;
                    state_next = first_phase(2'd3, ilen_reg, dlen_reg, ulen_reg, rcyc_reg);
                end else begin
                    run_next = run_reg + 32'd1;
                end
            end
            DUMP_RD: begin
                state_next = DUMP_CAP;
            end
            DUMP_CAP: begin
                // Read data arrives the cycle after the strobe.
                rdata_next = rdata_ext_2;
                state_next = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    if (cnt_reg == ulen_reg - 1'b1) begin
                        cnt_next   = '0;
                        state_next = FIN;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = DUMP_RD;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ilen_reg  <= '0;
            dlen_reg  <= '0;
            ulen_reg  <= '0;
            rcyc_reg  <= 32'd0;
            run_reg   <= 32'd0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ilen_reg  <= ilen_next;
            dlen_reg  <= dlen_next;
            ulen_reg  <= ulen_next;
            rcyc_reg  <= rcyc_next;
            run_reg   <= run_next;
            rdata_reg <= rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed and random sequences checked
// against an expected write list and data-memory image built from the stimulus.
module tb_mem_loader;
    localparam int CNT_W = 11;
    localparam int STEP  = 4;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] imem_len = '0, dmem_len = '0, dump_len = '0;
    logic [31:0]      run_cycles = 32'd0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = 32'd0;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready = 1'b0;
    logic             cpu_enable;
    logic [31:0]      addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic             wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];

    mem_loader #(.ADDR_STEP(STEP), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .dump_len(dump_len),
        .run_cycles(run_cycles), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Data memory seen by the loader's second port: one-cycle read latency.
    always @(posedge clk) begin
        if (wen_ext_2) mem[addr_ext_2[7:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // vmode: 0 random in_valid, 1 always, 2 toggling. rmode: 0 random out_ready,
    // 1 always, 2 low for three stalled cycles then high.
    task automatic run_seq(input int il, input int dl, input int rc, input int ul,
                           input int vmode, input int rmode);
        logic [31:0] words[$];
        logic [31:0] ia_q[$], id_q[$], da_q[$], dd_q[$], out_q[$];
        int          icyc[$];
        int          widx, cyc, run_n, ren_n, busy_bad, run_gap, stall_bad, stall_n;
        logic        run_seen, prev_run, prev_stall, fin;
        logic [31:0] prev_out;
        widx = 0; cyc = 0; run_n = 0; ren_n = 0; busy_bad = 0;
        run_gap = 0; stall_bad = 0; stall_n = 0;
        run_seen = 1'b0; prev_run = 1'b0; prev_stall = 1'b0; fin = 1'b0;
        prev_out = 32'd0;
        for (int k = 0; k <= il + dl; k++) words.push_back($urandom);
        for (int k = 0; k < dl; k++) ref_mem[k] = words[il + k];

        @(posedge clk); #1;
        imem_len = CNT_W'(il); dmem_len = CNT_W'(dl); dump_len = CNT_W'(ul);
        run_cycles = 32'(rc);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = words[0];
        out_ready = (rmode == 1);
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc > 1 && !busy) busy_bad++;
            if (wen_ext) begin
                ia_q.push_back(addr_ext); id_q.push_back(wdata_ext); icyc.push_back(cyc);
            end
            if (wen_ext_2) begin
                da_q.push_back(addr_ext_2); dd_q.push_back(wdata_ext_2);
            end
            if (cpu_enable) begin
                if (run_seen && !prev_run) run_gap++;
                run_n++;
                run_seen = 1'b1;
            end
            prev_run = cpu_enable;
            if (ren_ext_2) ren_n++;
            if (prev_stall && (!out_valid || out_data !== prev_out)) stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev_out = out_data;
            if (out_valid && !out_ready) stall_n++;
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (in_valid && in_ready && widx < words.size() - 1) widx++;
            if (done) fin = 1'b1;

            @(posedge clk); #1;
            // Spurious starts with junk lengths while busy must be ignored.
            start = !fin && ($urandom_range(0, 3) == 0);
            imem_len = CNT_W'($urandom_range(0, 7));
            dmem_len = CNT_W'($urandom_range(0, 7));
            dump_len = CNT_W'($urandom_range(0, 7));
            run_cycles = $urandom_range(0, 9);
            case (vmode)
                1: in_valid = 1'b1;
                2: in_valid = (cyc % 2 == 1);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            in_data = words[widx];
            case (rmode)
                1: out_ready = 1'b1;
                2: out_ready = (stall_n >= 3);
                default: out_ready = $urandom_range(0, 1) == 1;
            endcase
        end
        start = 1'b0;

        chk("done_seen", 32'(fin), 32'd1);
        chk("imem_count", 32'(ia_q.size()), 32'(il));
        for (int k = 0; k < ia_q.size() && k < il; k++) begin
            chk("imem_addr", ia_q[k], 32'(k * STEP));
            chk("imem_data", id_q[k], words[k]);
            if (vmode == 1 && k > 0) chk("imem_consec", 32'(icyc[k]), 32'(icyc[0] + k));
        end
        chk("dmem_count", 32'(da_q.size()), 32'(dl));
        for (int k = 0; k < da_q.size() && k < dl; k++) begin
            chk("dmem_addr", da_q[k], 32'(k * STEP));
            chk("dmem_data", dd_q[k], words[il + k]);
        end
        chk("run_len", 32'(run_n), 32'(rc));
        chk("run_contig", 32'(run_gap), 32'd0);
        chk("ren_count", 32'(ren_n), 32'(ul));
        chk("dump_count", 32'(out_q.size()), 32'(ul));
        for (int k = 0; k < out_q.size() && k < ul; k++)
            chk("dump_data", out_q[k], ref_mem[k]);
        chk("busy_during", 32'(busy_bad), 32'd0);
        chk("stall_stable", 32'(stall_bad), 32'd0);
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        $display("seq il=%0d dl=%0d rc=%0d ul=%0d imem_wr=%0d dmem_wr=%0d run=%0d dumped=%0d cycles=%0d",
                 il, dl, rc, ul, ia_q.size(), da_q.size(), run_n, out_q.size(), cyc);
    endtask

    initial begin
        int quiet_bad;
        for (int k = 0; k < 64; k++) begin
            logic [31:0] v;
            v = $urandom;
            mem[k] <= v;
            ref_mem[k] = v;
        end

        // Reset state
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_strobes", {28'd0, wen_ext, wen_ext_2, ren_ext_2, cpu_enable}, 32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        // Three instruction words, in_valid held high
        run_seq(3, 0, 0, 0, 1, 1);
        // Two data words with in_valid toggling
        run_seq(0, 2, 0, 0, 2, 1);
        // CPU run only
        run_seq(0, 0, 5, 0, 1, 1);
        // Dump two preset words with a three-cycle consumer stall
        mem[0] <= 32'h11; mem[1] <= 32'h22;
        ref_mem[0] = 32'h11; ref_mem[1] = 32'h22;
        run_seq(0, 0, 0, 2, 1, 2);
        // All phases empty
        run_seq(0, 0, 0, 0, 1, 1);

        // Asynchronous reset in LOAD_I after one word
        @(posedge clk); #1;
        imem_len = 3; dmem_len = 2; dump_len = 1; run_cycles = 4;
        start = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_wen", 32'(wen_ext), 32'd1);
        @(posedge clk); #2;
        arst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wen", 32'(wen_ext), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_addr", addr_ext, 32'd0);
        chk("arst_wdata", wdata_ext, 32'd0);
        chk("arst_port2", addr_ext_2 | wdata_ext_2, 32'd0);
        chk("arst_misc", {26'd0, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, out_valid, done}, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        quiet_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (wen_ext || wen_ext_2 || ren_ext_2 || cpu_enable || busy || done || in_ready)
                quiet_bad++;
        end
        chk("post_rst_quiet", 32'(quiet_bad), 32'd0);

        // Random sequences
        for (int s = 0; s < 10; s++)
            run_seq($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 5),
                    $urandom_range(0, 6), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR_STEP, default 4: address increment per word on both external memory ports (byte addressing).
REQ-002 Parameter CNT_W, default 11: width of the word-count inputs.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load/run/dump sequence.
REQ-006 imem_len  input  CNT_W  number of instruction words to load; sampled at accepted start.
REQ-007 dmem_len  input  CNT_W  number of data words to load; sampled at accepted start.
REQ-008 dump_len  input  CNT_W  number of data words to read back; sampled at accepted start.
REQ-009 run_cycles  input  32  number of cycles cpu_enable is held high; sampled at accepted start.
REQ-010 in_valid / in_data  input  1 / 32  load word stream; transfer occurs when in_valid and in_ready are both high.
REQ-011 in_ready  output  1  loader accepts a load word this cycle.
REQ-012 out_valid / out_data  output  1 / 32  dump word stream.
REQ-013 out_ready  input  1  consumer accepts out_data; transfer when out_valid and out_ready are both high.
REQ-014 cpu_enable  output  1  drives the CPU enable input.
REQ-015 addr_ext, wen_ext, ren_ext, wdata_ext  output  32,1,1,32  instruction-memory external port.
REQ-016 addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  output  32,1,1,32  data-memory external port.
REQ-017 rdata_ext_2  input  32  data-memory read word, valid the cycle after ren_ext_2.
REQ-018 busy / done  output  1 / 1  sequence in progress / one-cycle completion pulse.

Function
REQ-019 States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, FIN.
REQ-020 IDLE: start=1 latches all lengths, clears word counter and address to 0, enters LOAD_I; start is ignored in every other state.
REQ-021 Any phase with length 0 is skipped in the same transition (e.g. imem_len=0 goes directly to LOAD_D or later).
REQ-022 LOAD_I: in_ready=1; each transfer drives wen_ext=1, wdata_ext=in_data, addr_ext=counter*ADDR_STEP for exactly that cycle; after imem_len transfers, counter resets to 0 and state advances.
REQ-023 LOAD_D: identical to LOAD_I using the _2 port and dmem_len.
REQ-024 in_ready=0 in all states except LOAD_I and LOAD_D; wen_ext/wen_ext_2=0 whenever no transfer occurs.
REQ-025 RUN: cpu_enable=1 for exactly run_cycles consecutive cycles, 0 otherwise; run_cycles=0 skips RUN.
REQ-026 DUMP_RD: ren_ext_2=1 for one cycle at addr_ext_2=counter*ADDR_STEP; DUMP_CAP: registers rdata_ext_2 into out_data; DUMP_OUT: out_valid=1, out_data held stable until out_ready.
REQ-027 After each out transfer, counter increments; next read issues only after the transfer; after dump_len transfers, enter FIN.
REQ-028 FIN: done=1 for one cycle, return to IDLE.
REQ-029 busy=1 in every state except IDLE.
REQ-030 Counters wrap never: lengths above memory depth are the user's responsibility; address = counter*ADDR_STEP truncated to 32 bits.
REQ-031 ren_ext, wen_ext never asserted simultaneously with wen_ext_2/ren_ext_2 writes on the same port; ren_ext is held 0 always.

Reset
REQ-032 arst_n low, at any time, forces state IDLE, counters 0, and all outputs 0 (addresses, wdata, out_data, all strobes, cpu_enable, busy, done) without waiting for clk.
REQ-033 A reset during LOAD/RUN/DUMP abandons the sequence; no further memory strobe follows reset release until a new start.

Verification
REQ-034 imem_len=3, dmem_len=0, dump_len=0, run_cycles=0, words A,B,C with in_valid always 1 -> wen_ext pulses at addr 0,4,8 with A,B,C on consecutive cycles, then done pulse; busy 1 throughout.
REQ-035 dmem_len=2 with in_valid toggling 1,0,1 -> exactly two wen_ext_2 strobes at addr 0 and 4; no strobe in the in_valid=0 cycle.
REQ-036 run_cycles=5, other lengths 0 -> cpu_enable high exactly 5 cycles, then done.
REQ-037 dump_len=2, memory holds 0x11 at 0 and 0x22 at 4, out_ready low 3 cycles then high -> out_data 0x11 stable while stalled, then 0x22; exactly two ren_ext_2 strobes.
REQ-038 arst_n asserted mid LOAD_I after one word -> all outputs 0 immediately; after release, no strobes, busy=0; start pulse while busy is ignored.
